// File: rtl/input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// input_conditioner_pkg
// Shared constants for the holiday-lights front end and the LED rotator.
//   DEFAULT_DEBOUNCE_CYCLES : consecutive cycles an input must hold (20 ms @ 100 MHz)
//   DEFAULT_SYNC_STAGES     : synchroniser depth on every raw input bit
//   SWITCH_W                : width of the mode switch bank
//   LED_W                   : LED string width used by the rotator
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int SWITCH_W                = 3;
   localparam int LED_W                   = 16;

   // Counter width for a debounce window; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// Synchronises a WIDTH-bit raw input, debounces it as one word and emits a
// one-cycle strobe the cycle after the debounced value changes.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   raw     : asynchronous input word
//   stable  : debounced value
//   changed : registered pulse, high for the cycle after stable updates
// ---------------------------------------------------------------------------
module debounce_channel
   import input_conditioner_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable,
   output logic             changed
);

   localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] cand;
   logic [CNT_W-1:0] cnt;

   // Every bit is synchronised on its own; only the last stage is used.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // Any movement of the synchronised word restarts the window, so the word
   // is accepted as a whole and partial (skewed) values never reach stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand    <= '0;
         stable  <= '0;
         cnt     <= '0;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (sync != cand) begin
            cand <= sync;
            cnt  <= '0;
         end else if (cand != stable) begin
            if (cnt == CNT_LAST) begin
               stable  <= cand;
               cnt     <= '0;
               changed <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Front end for the LED rotator: cleans the push-button and mode switches.
// Ports:
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset
//   button_raw     : asynchronous push-button, active-high
//   switch_raw     : asynchronous mode switches
//   button_level   : debounced button level
//   button_press   : one-cycle pulse on an accepted press (0->1 only)
//   switch_stable  : debounced switch word
//   switch_changed : one-cycle pulse on every accepted switch change
// ---------------------------------------------------------------------------
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                button_raw,
   input  logic [SWITCH_W-1:0] switch_raw,
   output logic                button_level,
   output logic                button_press,
   output logic [SWITCH_W-1:0] switch_stable,
   output logic                switch_changed
);

   logic button_changed;

   debounce_channel #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_button (
      .clk     (clk),
      .rst     (rst),
      .raw     (button_raw),
      .stable  (button_level),
      .changed (button_changed)
   );

   debounce_channel #(
      .WIDTH           (SWITCH_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_switch (
      .clk     (clk),
      .rst     (rst),
      .raw     (switch_raw),
      .stable  (switch_stable),
      .changed (switch_changed)
   );

   // Both terms are flops; a release leaves the level low, which masks it.
   assign button_press = button_changed & button_level;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with a short debounce window.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

   localparam int D   = 8;
   localparam int S   = 2;
   localparam int LAT = S + D;

   logic       clk;
   logic       rst;
   logic       button_raw;
   logic [2:0] switch_raw;
   logic       button_level;
   logic       button_press;
   logic [2:0] switch_stable;
   logic       switch_changed;

   int checks = 0;
   int passes = 0;

   input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .SYNC_STAGES     (S)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .button_raw     (button_raw),
      .switch_raw     (switch_raw),
      .button_level   (button_level),
      .button_press   (button_press),
      .switch_stable  (switch_stable),
      .switch_changed (switch_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a raw sample reaches the debouncer S edges later; a
   // value is accepted once it has been seen on D+1 consecutive edges and
   // differs from the current debounced value.
   logic       m_b_hist [S];
   logic [2:0] m_s_hist [S];
   logic       m_b_last = 1'b0;
   logic [2:0] m_s_last = 3'b000;
   int         m_b_run  = 0;
   int         m_s_run  = 0;
   logic       m_b_seen;
   logic [2:0] m_s_seen;
   logic       exp_level = 1'b0;
   logic       exp_press = 1'b0;
   logic [2:0] exp_sw    = 3'b000;
   logic       exp_chg   = 1'b0;

   wire [5:0] dut_vec = {button_level, button_press, switch_stable, switch_changed};
   wire [5:0] exp_vec = {exp_level, exp_press, exp_sw, exp_chg};

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < S; i++) begin
            m_b_hist[i] = 1'b0;
            m_s_hist[i] = 3'b000;
         end
         m_b_last  = 1'b0;
         m_s_last  = 3'b000;
         m_b_run   = 0;
         m_s_run   = 0;
         exp_level = 1'b0;
         exp_press = 1'b0;
         exp_sw    = 3'b000;
         exp_chg   = 1'b0;
      end else begin
         m_b_seen = m_b_hist[S-1];
         m_s_seen = m_s_hist[S-1];
         for (int i = S - 1; i > 0; i--) begin
            m_b_hist[i] = m_b_hist[i-1];
            m_s_hist[i] = m_s_hist[i-1];
         end
         m_b_hist[0] = button_raw;
         m_s_hist[0] = switch_raw;

         m_b_run  = (m_b_seen == m_b_last) ? ((m_b_run < D + 1) ? m_b_run + 1 : m_b_run) : 1;
         m_s_run  = (m_s_seen == m_s_last) ? ((m_s_run < D + 1) ? m_s_run + 1 : m_s_run) : 1;
         m_b_last = m_b_seen;
         m_s_last = m_s_seen;

         exp_press = 1'b0;
         exp_chg   = 1'b0;
         if (m_b_run >= D + 1 && m_b_seen != exp_level) begin
            exp_level = m_b_seen;
            exp_press = m_b_seen;
         end
         if (m_s_run >= D + 1 && m_s_seen != exp_sw) begin
            exp_sw  = m_s_seen;
            exp_chg = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset holds everything at zero; release reveals held inputs LAT edges on.
   task automatic test_reset();
      int n;
      int presses;
      int changes;
      rst = 1'b1;
      button_raw = 1'b1;
      switch_raw = 3'b101;
      repeat (3) begin
         tick();
         checks++;
         if (dut_vec !== 6'b000000) $display("[TB] FAIL reset_outputs: got %b required 000000", dut_vec);
         else passes++;
      end
      rst = 1'b0;
      tick();
      n = 0;
      presses = 0;
      changes = 0;
      while (button_level !== 1'b1 && n < 30) begin
         tick();
         n++;
         presses += int'(button_press);
         changes += int'(switch_changed);
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL reset_model: got %b required %b", dut_vec, exp_vec);
         else passes++;
      end
      checks++;
      if (n !== LAT) $display("[TB] FAIL reset_latency: got %0d required %0d", n, LAT);
      else passes++;
      checks++;
      if (switch_stable !== 3'b101) $display("[TB] FAIL reset_switch_value: got %b required 101", switch_stable);
      else passes++;
      repeat (12) begin
         tick();
         presses += int'(button_press);
         changes += int'(switch_changed);
      end
      checks++;
      if (presses !== 1 || changes !== 1)
         $display("[TB] FAIL reset_strobe_count: got press=%0d chg=%0d required 1 and 1", presses, changes);
      else passes++;
   endtask

   // Clean press then clean release.
   task automatic test_clean_press();
      int n;
      int presses;
      button_raw = 1'b0;
      repeat (20) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL press_model: got %b required %b", dut_vec, exp_vec);
         else passes++;
      end
      button_raw = 1'b1;
      tick();
      n = 0;
      while (button_press !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (n !== LAT) $display("[TB] FAIL press_latency: got %0d required %0d", n, LAT);
      else passes++;
      presses = 1;
      repeat (19) begin
         tick();
         presses += int'(button_press);
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL press_model: got %b required %b", dut_vec, exp_vec);
         else passes++;
      end
      checks++;
      if (presses !== 1) $display("[TB] FAIL press_single: got %0d required 1", presses);
      else passes++;
      button_raw = 1'b0;
      tick();
      n = 0;
      presses = 0;
      while (button_level !== 1'b0 && n < 30) begin
         tick();
         n++;
         presses += int'(button_press);
      end
      checks++;
      if (n !== LAT) $display("[TB] FAIL release_latency: got %0d required %0d", n, LAT);
      else passes++;
      repeat (12) begin
         tick();
         presses += int'(button_press);
      end
      checks++;
      if (presses !== 0) $display("[TB] FAIL release_no_pulse: got %0d required 0", presses);
      else passes++;
   endtask

   // Bouncing press gives one pulse; a short glitch gives nothing.
   task automatic test_bounce();
      int n;
      int presses;
      int low_cycles;
      logic pattern [4];
      pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1; pattern[3] = 1'b0;
      presses = 0;
      for (int p = 0; p < 4; p++) begin
         button_raw = pattern[p];
         repeat (3) begin
            tick();
            presses += int'(button_press);
            checks++;
            if (dut_vec !== exp_vec) $display("[TB] FAIL bounce_model: got %b required %b", dut_vec, exp_vec);
            else passes++;
         end
      end
      button_raw = 1'b1;
      tick();
      n = 0;
      while (button_press !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      presses += int'(button_press);
      checks++;
      if (n !== LAT) $display("[TB] FAIL bounce_latency: got %0d required %0d", n, LAT);
      else passes++;
      repeat (15) begin
         tick();
         presses += int'(button_press);
      end
      checks++;
      if (presses !== 1) $display("[TB] FAIL bounce_single_press: got %0d required 1", presses);
      else passes++;
      low_cycles = 0;
      button_raw = 1'b0;
      repeat (D - 1) begin
         tick();
         low_cycles += int'(!button_level);
      end
      button_raw = 1'b1;
      repeat (20) begin
         tick();
         low_cycles += int'(!button_level);
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL glitch_model: got %b required %b", dut_vec, exp_vec);
         else passes++;
      end
      checks++;
      if (low_cycles !== 0) $display("[TB] FAIL glitch_ignored: got %0d low cycles required 0", low_cycles);
      else passes++;
   endtask

   // Skewed switch bits are accepted as one word with one strobe.
   task automatic test_switch_word();
      int changes;
      int partial;
      switch_raw = 3'b000;
      repeat (20) tick();
      changes = 0;
      partial = 0;
      switch_raw = 3'b001;
      repeat (2) begin
         tick();
         changes += int'(switch_changed);
      end
      switch_raw = 3'b011;
      repeat (20) begin
         tick();
         changes += int'(switch_changed);
         partial += int'(switch_stable == 3'b001);
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL switch_model: got %b required %b", dut_vec, exp_vec);
         else passes++;
      end
      checks++;
      if (partial !== 0 || changes !== 1)
         $display("[TB] FAIL switch_word: got partial=%0d chg=%0d required 0 and 1", partial, changes);
      else passes++;
      checks++;
      if (switch_stable !== 3'b011) $display("[TB] FAIL switch_final: got %b required 011", switch_stable);
      else passes++;
   endtask

   // Button and switches accepted together strobe in the same cycle.
   task automatic test_simultaneous();
      int n;
      button_raw = 1'b0;
      repeat (20) tick();
      button_raw = 1'b1;
      switch_raw = 3'b111;
      n = 0;
      while (button_press !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (switch_changed !== 1'b1 || switch_stable !== 3'b111)
         $display("[TB] FAIL simultaneous_strobes: got chg=%b sw=%b required 1 and 111", switch_changed, switch_stable);
      else passes++;
      repeat (15) tick();
   endtask

   // Reset during a pending change discards it; counting restarts afterwards.
   task automatic test_reset_mid();
      int n;
      int early;
      early = 0;
      switch_raw = 3'b010;
      repeat (5) begin
         tick();
         early += int'(switch_changed);
      end
      rst = 1'b1;
      tick();
      early += int'(switch_changed);
      rst = 1'b0;
      tick();
      n = 0;
      while (switch_changed !== 1'b1 && n < 30) begin
         tick();
         n++;
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL reset_mid_model: got %b required %b", dut_vec, exp_vec);
         else passes++;
      end
      checks++;
      if (early !== 0) $display("[TB] FAIL reset_mid_early: got %0d strobes required 0", early);
      else passes++;
      checks++;
      if (n !== LAT || switch_stable !== 3'b010)
         $display("[TB] FAIL reset_mid_latency: got n=%0d sw=%b required %0d and 010", n, switch_stable, LAT);
      else passes++;
      repeat (15) tick();
   endtask

   // Random holds and occasional resets compared cycle by cycle to the model.
   task automatic test_random();
      int b_hold;
      int s_hold;
      int last_chg;
      b_hold = 0;
      s_hold = 0;
      last_chg = -100;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (b_hold == 0) begin
            button_raw = 1'($urandom_range(0, 1));
            b_hold = int'($urandom_range(1, 14));
         end
         if (s_hold == 0) begin
            switch_raw = 3'($urandom_range(0, 7));
            s_hold = int'($urandom_range(1, 14));
         end
         rst = ($urandom_range(0, 199) == 0);
         b_hold--;
         s_hold--;
         tick();
         checks++;
         if (dut_vec !== exp_vec) $display("[TB] FAIL random_model: cycle %0d got %b required %b", cyc, dut_vec, exp_vec);
         else passes++;
         if (switch_changed === 1'b1) begin
            checks++;
            if (cyc - last_chg < D + 1)
               $display("[TB] FAIL random_spacing: got %0d cycles required >= %0d", cyc - last_chg, D + 1);
            else passes++;
            last_chg = cyc;
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      button_raw = 1'b0;
      switch_raw = 3'b000;
      test_reset();
      test_clean_press();
      test_bounce();
      test_switch_word();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
